// File: rtl/mmu_wr_responder_pkg.sv
// Shared types and helpers for the MMU write-side responder.
// Holds the address/data widths, the ready-mode encodings and the LFSR
// helpers used by every per-port ready generator.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_DWIDTH
`define DATA_DWIDTH 32
`endif
`ifndef MMU_RDY_ECHO
`define MMU_RDY_ECHO     2'd0
`define MMU_RDY_ALWAYS   2'd1
`define MMU_RDY_PERIODIC 2'd2
`define MMU_RDY_RANDOM   2'd3
`endif

package mmu_wr_responder_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_DWIDTH;

  typedef enum logic [1:0] {
    RDY_ECHO     = `MMU_RDY_ECHO,
    RDY_ALWAYS   = `MMU_RDY_ALWAYS,
    RDY_PERIODIC = `MMU_RDY_PERIODIC,
    RDY_RANDOM   = `MMU_RDY_RANDOM
  } rdy_mode_e;

  // Fibonacci LFSR, taps 16,14,13,11; shifts left, feedback enters bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Per-port seed; an all-zero state would lock the LFSR, so it is remapped.
  function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int idx);
    logic [15:0] s;
    s = base ^ 16'(idx + 1);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/mmu_rdy_gen.sv
// Per-port ready generator.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_mode           ready pattern select (echo/always/periodic/random)
//   i_rand_thresh    random-mode density: ready when lfsr[7:0] < thresh
//   i_req            this port's request (used by echo mode)
//   o_ready          registered ready for this port
// The phase counter and LFSR free-run in every mode so that switching
// modes never restarts their sequences.

module mmu_rdy_gen
  import mmu_wr_responder_pkg::*;
#(
  parameter int          ON_CYC    = 4,
  parameter int          OFF_CYC   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          PORT_IDX  = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_rand_thresh,
  input  logic       i_req,
  output logic       o_ready
);

  localparam int PERIOD = ON_CYC + OFF_CYC;
  localparam int PH_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_INIT = PH_W'(PORT_IDX % PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_ON   = PH_W'(ON_CYC);
  localparam logic [15:0]     LFSR_INIT = lfsr_seed(LFSR_SEED, PORT_IDX);

  logic [PH_W-1:0] phase;
  logic [15:0]     lfsr;
  rdy_mode_e       mode;

  assign mode = rdy_mode_e'(i_mode);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase   <= PH_INIT;
      lfsr    <= LFSR_INIT;
      o_ready <= 1'b0;
    end else begin
      phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      lfsr  <= lfsr_step(lfsr);
      unique case (mode)
        RDY_ECHO:     o_ready <= i_req;
        RDY_ALWAYS:   o_ready <= 1'b1;
        RDY_PERIODIC: o_ready <= (phase < PH_ON);
        RDY_RANDOM:   o_ready <= (lfsr[7:0] < i_rand_thresh);
      endcase
    end
  end

endmodule

// File: rtl/mmu_wr_responder.sv
// Multi-port MMU write-side responder (sink for SGDMA write traffic).
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_mode            ready pattern: 0 echo, 1 always, 2 periodic, 3 random
//   i_rand_thresh     random-mode ready density
//   i_clr             synchronous clear of counters, captures, error flags
//   i_mmu_wr_req      per-port request
//   i_mmu_wr_addr/dat flattened per-port address/data, port 0 in LSBs
//   o_mmu_wr_ready    per-port registered ready
//   o_acc_cnt         per-port accepted-beat counter (wraps)
//   o_last_addr/dat   per-port last accepted address/data
//   o_proto_err       per-port sticky handshake-violation flag

module mmu_wr_responder
  import mmu_wr_responder_pkg::*;
#(
  parameter int          N_PORTS   = 16,
  parameter int          CNT_W     = 16,
  parameter int          ON_CYC    = 4,
  parameter int          OFF_CYC   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [1:0]                  i_mode,
  input  logic [7:0]                  i_rand_thresh,
  input  logic                        i_clr,
  input  logic [N_PORTS-1:0]          i_mmu_wr_req,
  input  logic [N_PORTS*ADDR_W-1:0]   i_mmu_wr_addr,
  input  logic [N_PORTS*DATA_W-1:0]   i_mmu_wr_dat,
  output logic [N_PORTS-1:0]          o_mmu_wr_ready,
  output logic [N_PORTS*CNT_W-1:0]    o_acc_cnt,
  output logic [N_PORTS*ADDR_W-1:0]   o_last_addr,
  output logic [N_PORTS*DATA_W-1:0]   o_last_dat,
  output logic [N_PORTS-1:0]          o_proto_err
);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic              req;
    logic              rdy;
    logic              acc;
    logic              viol;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] dat_in;
    logic              pend_p1;
    logic [ADDR_W-1:0] pend_addr_p1;
    logic [DATA_W-1:0] pend_dat_p1;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [DATA_W-1:0] last_dat_q;
    logic              err_q;

    assign req     = i_mmu_wr_req[p];
    assign addr_in = i_mmu_wr_addr[p*ADDR_W +: ADDR_W];
    assign dat_in  = i_mmu_wr_dat[p*DATA_W +: DATA_W];

    mmu_rdy_gen #(
      .ON_CYC    (ON_CYC),
      .OFF_CYC   (OFF_CYC),
      .LFSR_SEED (LFSR_SEED),
      .PORT_IDX  (p)
    ) u_rdy_gen (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_mode        (i_mode),
      .i_rand_thresh (i_rand_thresh),
      .i_req         (req),
      .o_ready       (rdy)
    );

    assign acc = req & rdy;
    // A request left waiting must be held with unchanged payload.
    assign viol = pend_p1 & (~req | (addr_in != pend_addr_p1) | (dat_in != pend_dat_p1));

    // Stage p0 -> p1: remember the payload of a request that was not accepted.
    always_ff @(posedge i_clk) begin
      if (req & ~rdy) begin
        pend_addr_p1 <= addr_in;
        pend_dat_p1  <= dat_in;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        pend_p1     <= 1'b0;
        cnt_q       <= '0;
        last_addr_q <= '0;
        last_dat_q  <= '0;
        err_q       <= 1'b0;
      end else begin
        pend_p1 <= req & ~rdy;
        if (i_clr) begin
          cnt_q       <= '0;
          last_addr_q <= '0;
          last_dat_q  <= '0;
          err_q       <= 1'b0;
        end else begin
          if (acc) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            last_addr_q <= addr_in;
            last_dat_q  <= dat_in;
          end
          if (viol) err_q <= 1'b1;
        end
      end
    end

    assign o_mmu_wr_ready[p]                = rdy;
    assign o_acc_cnt[p*CNT_W +: CNT_W]      = cnt_q;
    assign o_last_addr[p*ADDR_W +: ADDR_W]  = last_addr_q;
    assign o_last_dat[p*DATA_W +: DATA_W]   = last_dat_q;
    assign o_proto_err[p]                   = err_q;
  end

endmodule

// File: tb/tb_mmu_wr_responder.sv
module tb_mmu_wr_responder;
  import mmu_wr_responder_pkg::*;

  localparam int NP = 16;
  localparam int CW = 16;
  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic [7:0]        thresh;
  logic              clr;
  logic [NP-1:0]     req;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  dat;
  logic [NP-1:0]     rdy;
  logic [NP*CW-1:0]  acc_cnt;
  logic [NP*AW-1:0]  last_addr;
  logic [NP*DW-1:0]  last_dat;
  logic [NP-1:0]     perr;

  always #5 clk = ~clk;

  mmu_wr_responder #(
    .N_PORTS(NP), .CNT_W(CW), .ON_CYC(4), .OFF_CYC(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_rand_thresh(thresh),
    .i_clr(clr), .i_mmu_wr_req(req), .i_mmu_wr_addr(addr), .i_mmu_wr_dat(dat),
    .o_mmu_wr_ready(rdy), .o_acc_cnt(acc_cnt), .o_last_addr(last_addr),
    .o_last_dat(last_dat), .o_proto_err(perr)
  );

  typedef enum int {K_RDY, K_CNT, K_ADDR, K_DAT, K_ERR} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          port;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic expect_val(input string name, input kind_e k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = k; e.port = p; e.lo = v; e.hi = v;
    sbq.push_back(e);
  endtask

  task automatic expect_range(input string name, input kind_e k, input int p,
                              input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    e.name = name; e.kind = k; e.port = p; e.lo = lo; e.hi = hi;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_e k, input int p);
    case (k)
      K_RDY:   return 32'(rdy[p]);
      K_CNT:   return 32'(acc_cnt[p*CW +: CW]);
      K_ADDR:  return 32'(last_addr[p*AW +: AW]);
      K_DAT:   return 32'(last_dat[p*DW +: DW]);
      default: return 32'(perr[p]);
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] a;
      e = sbq.pop_front();
      a = observe(e.kind, e.port);
      total++;
      if (a < e.lo || a > e.hi) begin
        bad++;
        if (e.lo == e.hi)
          $display("FAIL %s port%0d: got 0x%0h, expected 0x%0h", e.name, e.port, a, e.lo);
        else
          $display("FAIL %s port%0d: got %0d, expected %0d..%0d", e.name, e.port, a, e.lo, e.hi);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r;
    addr[p*AW +: AW] = a;
    dat[p*DW +: DW] = d;
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  int          pat0 [13] = '{0,1,1,1,1,0,0,1,1,1,1,0,0};
  int          pat1 [13] = '{0,1,1,1,0,0,1,1,1,1,0,0,1};
  logic [15:0] l0, l9;
  int          e0, e9;

  initial begin
    rst_n = 1'b1; mode = 2'd0; thresh = 8'd0; clr = 1'b0;
    req = '0; addr = '0; dat = '0;
    #1 rst_n = 1'b0;

    // ---- reset values ----
    step();
    expect_val("rst_rdy", K_RDY, 0, 0);
    expect_val("rst_rdy", K_RDY, 15, 0);
    expect_val("rst_cnt", K_CNT, 0, 0);
    expect_val("rst_addr", K_ADDR, 15, 0);
    expect_val("rst_dat", K_DAT, 0, 0);
    expect_val("rst_err", K_ERR, 15, 0);
    step(); rst_n = 1'b1;
    step(); step(); step();

    // ---- echo mode, port 3 ----
    step(); set_port(3, 1, 32'h100, 32'hD0); expect_val("echo_rdy_c0", K_RDY, 3, 0);
    step(); set_port(3, 1, 32'h100, 32'hD0); expect_val("echo_rdy_c1", K_RDY, 3, 1);
    step(); set_port(3, 1, 32'h104, 32'hD1); expect_val("echo_rdy_c2", K_RDY, 3, 1);
    step(); set_port(3, 1, 32'h108, 32'hD2); expect_val("echo_rdy_c3", K_RDY, 3, 1);
    step(); set_port(3, 1, 32'h10C, 32'hD3); expect_val("echo_rdy_c4", K_RDY, 3, 1);
    step(); set_port(3, 0, 32'h0, 32'h0);    expect_val("echo_rdy_tail", K_RDY, 3, 1);
    step();
    expect_val("echo_rdy_off", K_RDY, 3, 0);
    expect_val("echo_cnt", K_CNT, 3, 4);
    expect_val("echo_addr", K_ADDR, 3, 32'h10C);
    expect_val("echo_dat", K_DAT, 3, 32'hD3);
    expect_val("echo_err", K_ERR, 3, 0);
    expect_val("echo_cnt_other", K_CNT, 2, 0);

    // ---- always mode, all ports, 10 beats ----
    step(); mode = 2'd1; clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); clr = 1'b0;
      for (int p = 0; p < NP; p++) set_port(p, 1, AW'(p*256 + i), DW'(32'hA0000000 | (p*256 + i)));
      if (i == 0) expect_val("always_rdy", K_RDY, 7, 1);
    end
    step(); req = '0;
    for (int p = 0; p < NP; p++) begin
      expect_val("always_cnt", K_CNT, p, 10);
      expect_val("always_addr", K_ADDR, p, 32'(p*256 + 9));
      expect_val("always_err", K_ERR, p, 0);
    end
    expect_val("always_dat", K_DAT, 4, 32'hA0000409);

    // ---- periodic mode, reset asserted mid-burst ----
    step(); mode = 2'd2; clr = 1'b1; req = '0;
    step(); clr = 1'b0; set_port(0, 1, 32'h2000, 32'h5A5A);
    step(); step(); step();
    step(); rst_n = 1'b0;
    expect_val("midrst_rdy", K_RDY, 0, 0);
    expect_val("midrst_rdy", K_RDY, 1, 0);
    expect_val("midrst_cnt", K_CNT, 0, 0);
    expect_val("midrst_addr", K_ADDR, 0, 0);
    expect_val("midrst_err", K_ERR, 0, 0);
    step(); expect_val("midrst_rdy_hold", K_RDY, 0, 0);
    step(); expect_val("midrst_rdy_hold", K_RDY, 5, 0);
    for (int k = 0; k < 60; k++) begin
      step();
      if (k == 0) rst_n = 1'b1;
      set_port(0, 1, 32'h2000, 32'h5A5A);
      set_port(1, 1, 32'h3000, 32'h6B6B);
      if (k <= 12) begin
        expect_val("per_rdy_p0", K_RDY, 0, 32'(pat0[k]));
        expect_val("per_rdy_p1", K_RDY, 1, 32'(pat1[k]));
      end
    end
    step(); req = '0;
    expect_val("per_cnt_p0", K_CNT, 0, 40);
    expect_val("per_cnt_p1", K_CNT, 1, 39);
    expect_val("per_err_early", K_ERR, 0, 0);
    step();
    expect_val("per_drop_err_p0", K_ERR, 0, 1);
    expect_val("per_drop_err_p1", K_ERR, 1, 1);
    expect_val("per_err_idle", K_ERR, 2, 0);
    expect_val("per_cnt_hold", K_CNT, 0, 40);
    expect_val("per_addr_p0", K_ADDR, 0, 32'h2000);
    expect_val("per_addr_p1", K_ADDR, 1, 32'h3000);

    // ---- random mode after a fresh reset, thresh 128 ----
    step(); rst_n = 1'b0; mode = 2'd3; thresh = 8'd128; req = '0;
    step(); step();
    l0 = 16'hACE1 ^ 16'd1;
    l9 = 16'hACE1 ^ 16'd10;
    e0 = 0; e9 = 0;
    for (int k = 0; k < 4096; k++) begin
      step();
      if (k == 0) begin
        rst_n = 1'b1;
        for (int p = 0; p < NP; p++) set_port(p, 1, AW'(32'h4000 + p), DW'(32'h77 + p));
        expect_val("rnd_rdy_c0", K_RDY, 0, 0);
      end else begin
        logic r0, r9;
        r0 = (l0[7:0] < 8'd128);
        r9 = (l9[7:0] < 8'd128);
        if (k <= 16) begin
          expect_val("rnd_rdy_p0", K_RDY, 0, 32'(r0));
          expect_val("rnd_rdy_p9", K_RDY, 9, 32'(r9));
        end
        if (r0) e0++;
        if (r9) e9++;
        l0 = m_next(l0);
        l9 = m_next(l9);
      end
    end
    step(); req = '0;
    expect_val("rnd_cnt_p0", K_CNT, 0, 32'(e0));
    expect_val("rnd_cnt_p9", K_CNT, 9, 32'(e9));
    expect_range("rnd_frac_p0", K_CNT, 0, 1843, 2253);
    expect_range("rnd_frac_p9", K_CNT, 9, 1843, 2253);

    // ---- random mode thresh 0, protocol violation, clear vs accept ----
    step(); thresh = 8'd0; clr = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1, AW'(p*16 + 32'h40), DW'(p + 32'h900));
    for (int r = 1; r <= 20; r++) begin
      step(); clr = 1'b0;
      if (r == 20) begin
        expect_val("t0_rdy", K_RDY, 0, 0);
        expect_val("t0_rdy", K_RDY, 5, 0);
        expect_val("t0_rdy", K_RDY, 15, 0);
        expect_val("t0_cnt", K_CNT, 0, 0);
        expect_val("t0_cnt", K_CNT, 5, 0);
        expect_val("t0_err", K_ERR, 5, 0);
      end
    end
    step(); set_port(5, 0, 32'h0, 32'h0);
    step();
    expect_val("drop_err_set", K_ERR, 5, 1);
    expect_val("drop_err_other", K_ERR, 4, 0);
    step(); step();
    expect_val("drop_err_sticky", K_ERR, 5, 1);
    expect_val("drop_cnt", K_CNT, 5, 0);
    step(); mode = 2'd1;
    step(); set_port(5, 1, 32'h90, 32'h905); clr = 1'b1;
    expect_val("clracc_rdy", K_RDY, 5, 1);
    step(); clr = 1'b0; req = '0;
    expect_val("clracc_cnt", K_CNT, 5, 0);
    expect_val("clracc_err", K_ERR, 5, 0);
    expect_val("clracc_addr", K_ADDR, 5, 0);
    expect_val("clracc_cnt_other", K_CNT, 0, 0);
    step();
    expect_val("post_clr_err", K_ERR, 0, 0);
    expect_val("post_clr_err", K_ERR, 5, 0);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
